// File: rtl/mdu_if.sv
// E-stage multiply/divide unit bus: decoded op, operands, flush request and hazard
// query in; busy, stall and architectural HI/LO out.
interface mdu_if;
  logic [3:0]  md_op;
  logic [31:0] md_A;
  logic [31:0] md_B;
  logic        req;
  logic        usehilo_D;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output md_op, md_A, md_B, req, usehilo_D,
    input  busy, stall, HI, LO
  );

  modport slave (
    input  md_op, md_A, md_B, req, usehilo_D,
    output busy, stall, HI, LO
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide unit with HI/LO, fixed-latency sequencing and D-stage stall.
// Define MDU_MADD_EN to decode madd/maddu/msub/msubu (ops 7-10).
module mdu_sequencer #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam logic [3:0] MulCnt = 4'(MUL_CYCLES);
  localparam logic [3:0] DivCnt = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  logic op_mul, op_div, op_mthi, op_mtlo, op_signed, op_acc, op_sub;
  logic can_issue, start;

  always_comb begin
    op_mul    = 1'b0;
    op_div    = 1'b0;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
    op_signed = 1'b0;
    op_acc    = 1'b0;
    op_sub    = 1'b0;
    case (bus.md_op)
      4'd1: begin op_mul = 1'b1; op_signed = 1'b1; end
      4'd2: op_mul = 1'b1;
      4'd3: begin op_div = 1'b1; op_signed = 1'b1; end
      4'd4: op_div = 1'b1;
      4'd5: op_mthi = 1'b1;
      4'd6: op_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      4'd7:  begin op_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      4'd8:  begin op_mul = 1'b1; op_acc = 1'b1; end
      4'd9:  begin op_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      4'd10: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign can_issue = (state_q == StIdle) & ~bus.req;
  assign start     = (op_mul | op_div) & can_issue;

  // 33-bit operands let one signed datapath serve both signed and unsigned forms,
  // and keep -2^31 / -1 from overflowing before truncation.
  logic signed [32:0] a_ext, b_ext, b_div, quo, rem;
  logic signed [65:0] prod_full;
  logic [63:0]        prod, acc_base, mul_res, div_res;
  logic               b_zero;

  assign a_ext     = {op_signed & bus.md_A[31], bus.md_A};
  assign b_ext     = {op_signed & bus.md_B[31], bus.md_B};
  assign prod_full = a_ext * b_ext;
  assign prod      = prod_full[63:0];
  assign acc_base  = {hi_q, lo_q};

  always_comb begin
    mul_res = prod;
    if (op_acc) mul_res = op_sub ? (acc_base - prod) : (acc_base + prod);
  end

  assign b_zero = (bus.md_B == 32'd0);
  assign b_div  = b_zero ? 33'sd1 : b_ext;
  assign quo    = a_ext / b_div;
  assign rem    = a_ext % b_div;
  // Divide by zero captures the current HI/LO so the commit leaves them unchanged.
  assign div_res = b_zero ? acc_base : {rem[31:0], quo[31:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          {sh_hi_d, sh_lo_d} = op_div ? div_res : mul_res;
          cnt_d              = op_div ? DivCnt : MulCnt;
          state_d            = op_div ? StDiv : StMul;
        end else if (can_issue & op_mthi) begin
          hi_d = bus.md_A;
        end else if (can_issue & op_mtlo) begin
          lo_d = bus.md_A;
        end
      end
      StMul, StDiv: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.stall = bus.usehilo_D & (bus.busy | start);
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases then random ops against an
// arithmetic reference model of HI/LO and busy latency.
module tb_mdu_sequencer;

  localparam int MulN = 5;
  localparam int DivN = 10;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] m_hi, m_lo;

  mdu_if bus ();

  mdu_sequencer #(.MUL_CYCLES(MulN), .DIV_CYCLES(DivN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkint(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_cycles(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return MulN;
      4'd3, 4'd4: return DivN;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: return MulN;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint sa, sb, qa, qb, q, r;
    longint unsigned ua, ub;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {hi, lo};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return 64'(ua * ub);
      4'd3: begin
        if (b == 32'd0) return acc;
        qa = (sa < 0) ? -sa : sa;
        qb = (sb < 0) ? -sb : sb;
        q  = qa / qb;
        r  = qa % qb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return acc;
        return {a % b, a / b};
      end
      4'd5: return {a, lo};
      4'd6: return {hi, a};
`ifdef MDU_MADD_EN
      4'd7:  return acc + 64'(sa * sb);
      4'd8:  return acc + 64'(ua * ub);
      4'd9:  return acc - 64'(sa * sb);
      4'd10: return acc - 64'(ua * ub);
`endif
      default: return acc;
    endcase
  endfunction

  // Issues one op for a single cycle at posedge+1, then follows the busy period.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_hl, input logic intrude);
    logic [63:0] exp;
    int n, cyc;
    exp = ref_result(op, a, b, m_hi, m_lo);
    n   = ref_cycles(op);
    bus.md_op = op; bus.md_A = a; bus.md_B = b; bus.req = 1'b0; bus.usehilo_D = use_hl;
    #1;
    check1("busy_at_issue", bus.busy, 1'b0);
    check1("stall_at_issue", bus.stall, use_hl & (n != 0));
    @(posedge clk); #1;
    bus.md_op = 4'd0; bus.md_A = $urandom; bus.md_B = $urandom;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 32) begin
      bus.md_op = (intrude && cyc == 2) ? 4'd1 : 4'd0;
      #1;
      check1("stall_busy", bus.stall, use_hl);
      check32("hi_hold", bus.HI, m_hi);
      check32("lo_hold", bus.LO, m_lo);
      cyc++;
      @(posedge clk); #1;
    end
    bus.md_op = 4'd0;
    checkint("busy_cycles", cyc, n);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    check1("busy_after", bus.busy, 1'b0);
    check32("hi_result", bus.HI, m_hi);
    check32("lo_result", bus.LO, m_lo);
    if (intrude) begin
      @(posedge clk); #1;
      check1("intruder_dropped", bus.busy, 1'b0);
      check32("intruder_hi", bus.HI, m_hi);
    end
  endtask

  initial begin
    logic [3:0] rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.md_op = 4'd0; bus.md_A = 32'd0; bus.md_B = 32'd0;
    bus.req = 1'b0; bus.usehilo_D = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_stall", bus.stall, 1'b0);
    check32("reset_hi", bus.HI, 32'd0);
    check32("reset_lo", bus.LO, 32'd0);
    reset = 1'b0;

    // mult / multu spot values
    run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
    check32("mult_hi_const", bus.HI, 32'hFFFF_FFFF);
    check32("mult_lo_const", bus.LO, 32'hFFFF_FFFE);
    run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1);
    check32("multu_hi_const", bus.HI, 32'h0000_0001);
    check32("multu_lo_const", bus.LO, 32'hFFFF_FFFE);

    // signed divide, with an op dropped while busy
    run_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1);
    check32("div_lo_const", bus.LO, 32'hFFFF_FFFD);
    check32("div_hi_const", bus.HI, 32'hFFFF_FFFF);

    // divide by zero keeps HI/LO
    run_op(4'd5, 32'h11, 32'h0, 1'b0, 1'b0);
    run_op(4'd6, 32'h22, 32'h0, 1'b0, 1'b0);
    run_op(4'd4, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    check32("divz_hi_const", bus.HI, 32'h11);
    check32("divz_lo_const", bus.LO, 32'h22);

    // req suppresses a start
    bus.md_op = 4'd1; bus.md_A = 32'hFFFF_FFFF; bus.md_B = 32'h2;
    bus.req = 1'b1; bus.usehilo_D = 1'b1;
    #1;
    check1("req_stall", bus.stall, 1'b0);
    @(posedge clk); #1;
    bus.md_op = 4'd0; bus.req = 1'b0;
    check1("req_busy", bus.busy, 1'b0);
    check32("req_hi", bus.HI, m_hi);
    check32("req_lo", bus.LO, m_lo);
    run_op(4'd6, 32'h1234, 32'h0, 1'b0, 1'b0);
    check32("mtlo_const", bus.LO, 32'h1234);

    // reset three cycles into a divide
    run_op(4'd5, 32'hAA, 32'h0, 1'b0, 1'b0);
    bus.md_op = 4'd3; bus.md_A = 32'd100; bus.md_B = 32'd7;
    @(posedge clk); #1;
    bus.md_op = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check1("mid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check1("midrst_busy", bus.busy, 1'b0);
    check32("midrst_hi", bus.HI, 32'd0);
    check32("midrst_lo", bus.LO, 32'd0);
    repeat (DivN) @(posedge clk);
    #1;
    check32("midrst_no_commit", bus.LO, 32'd0);

    // accumulate op (or its absence)
    run_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd6, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(4'd7, 32'd3, 32'd4, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
    check32("madd_lo_const", bus.LO, 32'd17);
`else
    check32("madd_off_lo", bus.LO, 32'd5);
`endif

    // random ops, back-to-back issue
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
